// File: rtl/adc_poly_pkg.sv
// Shared constants, section encodings and FSM states for the ADC polynomial
// linearisation path.
package adc_poly_pkg;

  localparam int POLY_ORDER = 10;
  localparam int NUM_COEFF  = POLY_ORDER + 1;
  localparam int COEFF_W    = 32;
  localparam int COEFF_FRAC = 24;

  typedef enum logic [1:0] {
    SEC1 = 2'b00,
    SEC2 = 2'b01,
    SEC3 = 2'b10,
    SEC4 = 2'b11
  } sec_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_e;

  localparam logic signed [COEFF_W-1:0] MAX_POS = {1'b0, {(COEFF_W-1){1'b1}}};
  localparam logic signed [COEFF_W-1:0] MAX_NEG = {1'b1, {(COEFF_W-1){1'b0}}};

endpackage

// File: rtl/poly_mac_sat.sv
// Combinational Horner step: sat(((acc * x) >>> (ADC_W-1)) + coeff), with an
// overflow flag. Shared by the correction stages.
module poly_mac_sat #(
  parameter int ADC_W   = 12,
  parameter int COEFF_W = 32
) (
  input  logic [COEFF_W-1:0] acc,
  input  logic [ADC_W-1:0]   x,
  input  logic [COEFF_W-1:0] coeff,
  output logic [COEFF_W-1:0] result,
  output logic               ovf
);

  localparam int PW = COEFF_W + ADC_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] SUM_MAX = SW'({1'b0, {(COEFF_W-1){1'b1}}});
  localparam logic signed [SW-1:0] SUM_MIN = ~SUM_MAX;

  logic signed [PW-1:0] acc_ext;
  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [SW-1:0] sum;

  always_comb begin
    acc_ext = PW'($signed(acc));
    x_ext   = PW'($signed(x));
    prod    = acc_ext * x_ext;
    shifted = prod >>> (ADC_W - 1);
    sum     = SW'(shifted) + SW'($signed(coeff));
    result  = sum[COEFF_W-1:0];
    ovf     = 1'b0;
    if (sum > SUM_MAX) begin
      result = SUM_MAX[COEFF_W-1:0];
      ovf    = 1'b1;
    end else if (sum < SUM_MIN) begin
      result = SUM_MIN[COEFF_W-1:0];
      ovf    = 1'b1;
    end
  end

endmodule

// File: rtl/adc_poly_eval.sv
// Sequential degree-10 Horner evaluator with valid/ready handshakes.
// Define ADC_POLY_SAT_FLAG_EN to add the sat_o saturation-seen output.
module adc_poly_eval
  import adc_poly_pkg::*;
#(
  parameter int ADC_W      = 12,
  parameter int COEFF_W    = adc_poly_pkg::COEFF_W,
  parameter int COEFF_FRAC = adc_poly_pkg::COEFF_FRAC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADC_W-1:0]   in_sample,
  input  logic [1:0]         in_section,
  output logic [1:0]         sec_o,
  input  logic [COEFF_W-1:0] coeff0_i,
  input  logic [COEFF_W-1:0] coeff1_i,
  input  logic [COEFF_W-1:0] coeff2_i,
  input  logic [COEFF_W-1:0] coeff3_i,
  input  logic [COEFF_W-1:0] coeff4_i,
  input  logic [COEFF_W-1:0] coeff5_i,
  input  logic [COEFF_W-1:0] coeff6_i,
  input  logic [COEFF_W-1:0] coeff7_i,
  input  logic [COEFF_W-1:0] coeff8_i,
  input  logic [COEFF_W-1:0] coeff9_i,
  input  logic [COEFF_W-1:0] coeff10_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_data
`ifdef ADC_POLY_SAT_FLAG_EN
  ,
  output logic               sat_o
`endif
);

  localparam int KW = $clog2(NUM_COEFF);
  localparam logic [KW-1:0] K_LAST = KW'(POLY_ORDER);

  if (COEFF_FRAC >= COEFF_W) begin : g_frac_check
    $error("COEFF_FRAC must be smaller than COEFF_W");
  end

  state_e               state, state_nxt;
  logic [KW-1:0]        k;
  logic [COEFF_W-1:0]   acc;
  logic [ADC_W-1:0]     x_r;
  logic [COEFF_W-1:0]   coeff_k;
  logic [COEFF_W-1:0]   mac_res;
  logic                 mac_ovf;
  logic                 accept;

  always_comb begin
    coeff_k = '0;
    case (k)
      KW'(1):  coeff_k = coeff1_i;
      KW'(2):  coeff_k = coeff2_i;
      KW'(3):  coeff_k = coeff3_i;
      KW'(4):  coeff_k = coeff4_i;
      KW'(5):  coeff_k = coeff5_i;
      KW'(6):  coeff_k = coeff6_i;
      KW'(7):  coeff_k = coeff7_i;
      KW'(8):  coeff_k = coeff8_i;
      KW'(9):  coeff_k = coeff9_i;
      KW'(10): coeff_k = coeff10_i;
      default: coeff_k = '0;
    endcase
  end

  poly_mac_sat #(
    .ADC_W   (ADC_W),
    .COEFF_W (COEFF_W)
  ) u_mac (
    .acc    (acc),
    .x      (x_r),
    .coeff  (coeff_k),
    .result (mac_res),
    .ovf    (mac_ovf)
  );

  // in_ready follows out_ready only in DONE so a waiting sample can enter on
  // the same edge the result is taken.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = ITER;
      ITER: if (k == K_LAST) state_nxt = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      acc      <= '0;
      x_r      <= '0;
      sec_o    <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_r   <= in_sample;
        sec_o <= in_section;
      end
      case (state)
        LOAD: begin
          acc <= coeff0_i;
          k   <= KW'(1);
        end
        ITER: begin
          acc <= mac_res;
          k   <= k + KW'(1);
          if (k == K_LAST) out_data <= mac_res;
        end
        default: ;
      endcase
    end
  end

`ifdef ADC_POLY_SAT_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_o <= 1'b0;
    end else if (accept) begin
      sat_o <= 1'b0;
    end else if (state == ITER && mac_ovf) begin
      sat_o <= 1'b1;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = mac_ovf;
`endif

endmodule
